// File: rtl/reset_sequencer.sv
// reset_sequencer: turns a raw push-button into a sequenced SDRAM global/soft reset and CPU hold.
// Optional calibration-timeout auto-retry is built when RESET_SEQ_AUTO_RETRY_EN is defined.
module reset_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4000000,
  parameter int unsigned GLOBAL_HOLD     = 1024,
  parameter int unsigned SOFT_HOLD       = 1024,
  parameter int unsigned CAL_TIMEOUT     = 50000000,
  parameter int unsigned START_DELAY     = 256
`ifdef RESET_SEQ_AUTO_RETRY_EN
  ,
  parameter int unsigned MAX_RETRIES     = 3
`endif
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_key_n,
  input  logic       i_calib_done,
  output logic       o_global_reset_n,
  output logic       o_soft_reset_n,
  output logic       o_cpu_reset,
  output logic [2:0] o_state,
  output logic       o_fault
);

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_GLOBAL   = 3'd1,
    ST_SOFT     = 3'd2,
    ST_WAIT_CAL = 3'd3,
    ST_START    = 3'd4,
    ST_FAULT    = 3'd5
  } state_e;

  localparam logic [31:0] DEB_LAST    = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] GLOBAL_LAST = 32'(GLOBAL_HOLD - 1);
  localparam logic [31:0] SOFT_LAST   = 32'(SOFT_HOLD - 1);
  localparam logic [31:0] CAL_LAST    = 32'(CAL_TIMEOUT - 1);
  localparam logic [31:0] START_LAST  = 32'(START_DELAY - 1);

  logic [1:0]  sync_q;
  logic        key_s;
  logic [31:0] deb_cnt_q, deb_cnt_d;
  logic        deb_key_q, deb_key_d;
  logic        press_q, press_d;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        glob_q, glob_d;
  logic        soft_q, soft_d;
  logic        cpu_q, cpu_d;
  logic        fault_q, fault_d;

`ifdef RESET_SEQ_AUTO_RETRY_EN
  localparam int RW = $clog2(MAX_RETRIES + 2);
  logic [RW-1:0] retries_q;
  logic          retry_inc;
`endif

  assign key_s = sync_q[1];

  // The debounced level only moves after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    deb_cnt_d = '0;
    deb_key_d = deb_key_q;
    press_d   = 1'b0;
    if (key_s != deb_key_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_key_d = key_s;
        press_d   = ~key_s;
      end else begin
        deb_cnt_d = deb_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q    <= 2'b11;
      deb_cnt_q <= '0;
      deb_key_q <= 1'b1;
      press_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], i_key_n};
      deb_cnt_q <= deb_cnt_d;
      deb_key_q <= deb_key_d;
      press_q   <= press_d;
    end
  end

  // Next state: a press overrides every other transition, including timeouts.
  always_comb begin
    state_d = state_q;
`ifdef RESET_SEQ_AUTO_RETRY_EN
    retry_inc = 1'b0;
`endif
    if (press_q) begin
      state_d = ST_GLOBAL;
    end else begin
      case (state_q)
        ST_GLOBAL:   if (cnt_q == GLOBAL_LAST) state_d = ST_SOFT;
        ST_SOFT:     if (cnt_q == SOFT_LAST) state_d = ST_WAIT_CAL;
        ST_WAIT_CAL: begin
          if (i_calib_done) begin
            state_d = ST_START;
          end else if (cnt_q == CAL_LAST) begin
`ifdef RESET_SEQ_AUTO_RETRY_EN
            if (retries_q < RW'(MAX_RETRIES)) begin
              state_d   = ST_GLOBAL;
              retry_inc = 1'b1;
            end else begin
              state_d = ST_FAULT;
            end
`else
            state_d = ST_FAULT;
`endif
          end
        end
        ST_START:    if (cnt_q == START_LAST) state_d = ST_RUN;
        ST_RUN:      state_d = ST_RUN;
        ST_FAULT:    state_d = ST_FAULT;
        default:     state_d = ST_GLOBAL;
      endcase
    end

    if (press_q || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (state_q == ST_RUN || state_q == ST_FAULT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Outputs decode the upcoming state so the registered pins line up with o_state.
  always_comb begin
    glob_d  = 1'b1;
    soft_d  = 1'b1;
    cpu_d   = 1'b1;
    fault_d = 1'b0;
    case (state_d)
      ST_GLOBAL: begin
        glob_d = 1'b0;
        soft_d = 1'b0;
      end
      ST_SOFT:  soft_d  = 1'b0;
      ST_RUN:   cpu_d   = 1'b0;
      ST_FAULT: fault_d = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_GLOBAL;
      cnt_q   <= '0;
      glob_q  <= 1'b0;
      soft_q  <= 1'b0;
      cpu_q   <= 1'b1;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      glob_q  <= glob_d;
      soft_q  <= soft_d;
      cpu_q   <= cpu_d;
      fault_q <= fault_d;
    end
  end

`ifdef RESET_SEQ_AUTO_RETRY_EN
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      retries_q <= '0;
    end else if (press_q || (state_d == ST_RUN && state_q != ST_RUN)) begin
      retries_q <= '0;
    end else if (retry_inc) begin
      retries_q <= retries_q + 1'b1;
    end
  end
`endif

  assign o_global_reset_n = glob_q;
  assign o_soft_reset_n   = soft_q;
  assign o_cpu_reset      = cpu_q;
  assign o_state          = state_q;
  assign o_fault          = fault_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed vector table, corner-case sequences,
// and randomized key/calibration stimulus against a deadline-based reference model.
module tb_reset_sequencer;

  localparam int DEB = 4;
  localparam int GH  = 8;
  localparam int SH  = 8;
  localparam int CT  = 32;
  localparam int SD  = 4;
`ifdef RESET_SEQ_AUTO_RETRY_EN
  localparam int MR  = 3;
`endif

  localparam int P_RUN = 0, P_GLOBAL = 1, P_SOFT = 2, P_WAIT = 3, P_START = 4, P_FAULT = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic       calib = 1'b0;
  logic       glob_n, soft_n, cpu_rst, fault;
  logic [2:0] state;

  always #5 clk = ~clk;

  reset_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .GLOBAL_HOLD    (GH),
    .SOFT_HOLD      (SH),
    .CAL_TIMEOUT    (CT),
    .START_DELAY    (SD)
  ) dut (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .i_key_n         (key_n),
    .i_calib_done    (calib),
    .o_global_reset_n(glob_n),
    .o_soft_reset_n  (soft_n),
    .o_cpu_reset     (cpu_rst),
    .o_state         (state),
    .o_fault         (fault)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: phase plus absolute deadline edge, key path as a sample window.
  int m_phase, m_deadline, m_edge, m_retries;
  bit m_fault, m_deb, m_press, m_ks1, m_ks2;
  bit m_hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0d expected=%0d", name, m_edge, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_phase = P_GLOBAL; m_edge = 0; m_deadline = GH;
    m_fault = 1'b0; m_retries = 0; m_deb = 1'b1; m_press = 1'b0;
    m_ks1 = 1'b1; m_ks2 = 1'b1;
    m_hist.delete();
  endfunction

  function automatic void enter(int p, int dur);
    m_phase = p;
    m_deadline = m_edge + dur;
  endfunction

  function automatic void model_edge(bit key, bit cal);
    bit all_diff;
    m_edge++;
    if (m_press) begin
      enter(P_GLOBAL, GH);
      m_fault = 1'b0;
      m_retries = 0;
    end else begin
      case (m_phase)
        P_GLOBAL: if (m_edge == m_deadline) enter(P_SOFT, SH);
        P_SOFT:   if (m_edge == m_deadline) enter(P_WAIT, CT);
        P_WAIT: begin
          if (cal) enter(P_START, SD);
          else if (m_edge == m_deadline) begin
`ifdef RESET_SEQ_AUTO_RETRY_EN
            if (m_retries < MR) begin
              m_retries++;
              enter(P_GLOBAL, GH);
            end else begin
              enter(P_FAULT, 0);
              m_fault = 1'b1;
            end
`else
            enter(P_FAULT, 0);
            m_fault = 1'b1;
`endif
          end
        end
        P_START: if (m_edge == m_deadline) begin
          enter(P_RUN, 0);
          m_retries = 0;
        end
        default: ;
      endcase
    end
    m_hist.push_back(m_ks2);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    m_press = 1'b0;
    if (m_hist.size() == DEB) begin
      all_diff = 1'b1;
      foreach (m_hist[i]) if (m_hist[i] == m_deb) all_diff = 1'b0;
      if (all_diff) begin
        m_deb = ~m_deb;
        m_press = (m_deb == 1'b0);
      end
    end
    m_ks2 = m_ks1;
    m_ks1 = key;
  endfunction

  task automatic cmp_model();
    chk("model.glob_n", glob_n, (m_phase == P_GLOBAL) ? 0 : 1);
    chk("model.soft_n", soft_n, (m_phase == P_GLOBAL || m_phase == P_SOFT) ? 0 : 1);
    chk("model.cpu", cpu_rst, (m_phase == P_RUN) ? 0 : 1);
    chk("model.state", state, m_phase);
    chk("model.fault", fault, m_fault);
  endtask

  task automatic step(input bit key, input bit cal);
    key_n = key;
    calib = cal;
    @(posedge clk);
    model_edge(key, cal);
    #1;
    cmp_model();
  endtask

  task automatic expect_out(input string tag, input bit g, input bit s, input bit c,
                            input int st, input bit f);
    chk({tag, ".glob_n"}, glob_n, g);
    chk({tag, ".soft_n"}, soft_n, s);
    chk({tag, ".cpu"}, cpu_rst, c);
    chk({tag, ".state"}, state, st);
    chk({tag, ".fault"}, fault, f);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_n = 1'b1;
    calib = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expect_out("reset", 1'b0, 1'b0, 1'b1, P_GLOBAL, 1'b0);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit key; bit cal; int n;
    bit g; bit s; bit c; int st; bit f;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fault_edge;
    int key_hold, cal_hold;
    bit rk, rc;

    tbl[0]  = '{1'b1, 1'b0, 7,  1'b0, 1'b0, 1'b1, P_GLOBAL, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b1, P_SOFT,   1'b0};
    tbl[2]  = '{1'b1, 1'b1, 7,  1'b1, 1'b0, 1'b1, P_SOFT,   1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b1, P_WAIT,   1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b1, P_START,  1'b0};
    tbl[5]  = '{1'b1, 1'b1, 3,  1'b1, 1'b1, 1'b1, P_START,  1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b0, P_RUN,    1'b0};
    tbl[7]  = '{1'b0, 1'b1, 3,  1'b1, 1'b1, 1'b0, P_RUN,    1'b0};
    tbl[8]  = '{1'b1, 1'b0, 6,  1'b1, 1'b1, 1'b0, P_RUN,    1'b0};
    tbl[9]  = '{1'b0, 1'b1, 10, 1'b0, 1'b0, 1'b1, P_GLOBAL, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 5,  1'b1, 1'b0, 1'b1, P_SOFT,   1'b0};
    tbl[11] = '{1'b1, 1'b1, 8,  1'b1, 1'b1, 1'b1, P_WAIT,   1'b0};
    tbl[12] = '{1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b1, P_START,  1'b0};
    tbl[13] = '{1'b1, 1'b1, 4,  1'b1, 1'b1, 1'b0, P_RUN,    1'b0};

    // Power-up sequence, glitch rejection and a full key-press restart
    do_reset();
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].key, tbl[i].cal);
      expect_out($sformatf("tbl[%0d]", i), tbl[i].g, tbl[i].s, tbl[i].c, tbl[i].st, tbl[i].f);
    end

    // Calibration never completes -> FAULT, then a press clears it
`ifdef RESET_SEQ_AUTO_RETRY_EN
    fault_edge = 4 * (GH + SH + CT);
`else
    fault_edge = GH + SH + CT;
`endif
    do_reset();
    for (int i = 1; i < fault_edge; i++) begin
      step(1'b1, 1'b0);
`ifdef RESET_SEQ_AUTO_RETRY_EN
      if (i == GH + SH + CT) expect_out("retry1", 1'b0, 1'b0, 1'b1, P_GLOBAL, 1'b0);
`endif
    end
    expect_out("pre_fault", 1'b1, 1'b1, 1'b1, P_WAIT, 1'b0);
    step(1'b1, 1'b0);
    expect_out("fault", 1'b1, 1'b1, 1'b1, P_FAULT, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    expect_out("fault_held", 1'b1, 1'b1, 1'b1, P_FAULT, 1'b1);
    step(1'b0, 1'b0);
    expect_out("fault_press", 1'b0, 1'b0, 1'b1, P_GLOBAL, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
    expect_out("fault_recover", 1'b1, 1'b1, 1'b0, P_RUN, 1'b0);

    // Press landing in SOFT at count 5
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    expect_out("soft_cnt5", 1'b1, 1'b0, 1'b1, P_SOFT, 1'b0);
    step(1'b0, 1'b0);
    expect_out("soft_press", 1'b0, 1'b0, 1'b1, P_GLOBAL, 1'b0);
    for (int i = 0; i < GH - 1; i++) step(1'b0, 1'b0);
    expect_out("soft_glob_last", 1'b0, 1'b0, 1'b1, P_GLOBAL, 1'b0);
    step(1'b0, 1'b0);
    expect_out("soft_glob_rel", 1'b1, 1'b0, 1'b1, P_SOFT, 1'b0);

    // Asynchronous reset in the middle of WAIT_CAL
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    expect_out("wait_cal", 1'b1, 1'b1, 1'b1, P_WAIT, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, 1'b0, 1'b1, P_GLOBAL, 1'b0);

    // Randomized key and calibration activity against the model
    do_reset();
    key_hold = 0;
    cal_hold = 0;
    rk = 1'b1;
    rc = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (key_hold == 0) begin
        rk = ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
        key_hold = $urandom_range(1, 12);
      end
      if (cal_hold == 0) begin
        rc = $urandom_range(0, 1) ? 1'b1 : 1'b0;
        cal_hold = $urandom_range(1, 60);
      end
      key_hold--;
      cal_hold--;
      step(rk, rc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
